apb_int_arbiter: RTL and testbench



---
 rtl/apb_int_arbiter.sv | 151 +++++++++++++++
 tb/tb_apb_int_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_int_arbiter.sv
// Interrupt arbiter: synchronises sources, latches edge events into pending,
// and presents one enabled source (fixed-priority or round-robin) until it is acknowledged.
module apb_int_arbiter #(
  parameter int unsigned NUM_SRC   = 32,
  parameter logic [31:0] EDGE_MASK = 32'h0000_7700
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NUM_SRC-1:0] int_src,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq_valid,
  output logic [4:0]         irq_id,
  input  logic               irq_ack
);

  localparam int unsigned IDW = 5;
  localparam int unsigned SW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [NUM_SRC-1:0] EDGE_V = EDGE_MASK[NUM_SRC-1:0];

  typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_GAP} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
  logic [NUM_SRC-1:0] pend_edge_q, pend_edge_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic               mode_q, mode_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               irq_valid_q, irq_valid_d;
  logic [IDW-1:0]     irq_id_q, irq_id_d;

  logic [NUM_SRC-1:0] pending, eligible, ack_clr, w1c;
  logic [IDW-1:0]     arb_start, win_id, ptr_next;
  logic               win_found;

  // Source synchroniser plus one extra stage for rising-edge detection
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= int_src;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pending  = (pend_edge_q & EDGE_V) | (s2_q & ~EDGE_V);
  assign eligible = pending & enable_q;

  // A new rising edge is ORed in after the clear, so it survives a same-cycle ack/W1C
  always_comb begin
    ack_clr = '0;
    if (state_q == ST_PRESENT && irq_ack) ack_clr = NUM_SRC'(1) << irq_id_q;
    w1c = (cfg_wr && cfg_addr == 2'd1) ? cfg_wdata[NUM_SRC-1:0] : '0;
    pend_edge_d = ((pend_edge_q & ~(ack_clr | w1c)) | (s2_q & ~s3_q)) & EDGE_V;
  end

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    if (cfg_wr && cfg_addr == 2'd0) enable_d = cfg_wdata[NUM_SRC-1:0];
    if (cfg_wr && cfg_addr == 2'd2) mode_d = cfg_wdata[0];
  end

  // Ascending search with wrap; fixed priority is the same search from index 0
  assign arb_start = mode_q ? rr_ptr_q : '0;

  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = 32'(arb_start) + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!win_found && eligible[SW'(idx)]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  assign ptr_next = (win_id == IDW'(NUM_SRC - 1)) ? '0 : win_id + IDW'(1);

  // Presentation FSM
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d     = ST_PRESENT;
          irq_valid_d = 1'b1;
          irq_id_d    = win_id;
          rr_ptr_d    = ptr_next;
        end
      end
      ST_PRESENT: begin
        if (irq_ack) begin
          state_d     = ST_GAP;
          irq_valid_d = 1'b0;
        end
      end
      ST_GAP: state_d = ST_IDLE;
      default: begin
        state_d     = ST_IDLE;
        irq_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      pend_edge_q <= '0;
      enable_q    <= '0;
      mode_q      <= 1'b0;
      rr_ptr_q    <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_edge_q <= pend_edge_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      rr_ptr_q    <= rr_ptr_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata[NUM_SRC-1:0] = enable_q;
      2'd1:    cfg_rdata[NUM_SRC-1:0] = pending;
      2'd2:    cfg_rdata[0]           = mode_q;
      default: cfg_rdata[5:0]         = {irq_valid_q, irq_id_q};
    endcase
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;

endmodule

// File: tb/tb_apb_int_arbiter.sv
// Bench for apb_int_arbiter: directed scenarios with literal expectations plus a
// behavioural reference model compared against the DUT every cycle.
module tb_apb_int_arbiter;

  localparam logic [31:0] EDGE = 32'h0000_7700;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [31:0] int_src = '0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        irq_valid;
  logic [4:0]  irq_id;
  logic        irq_ack = 1'b0;

  int checks = 0;
  int failures = 0;
  logic done = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_int_arbiter #(.NUM_SRC(32), .EDGE_MASK(EDGE)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .int_src(int_src),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw source history, edge-event pending set, and a presentation record
  logic [31:0] m_h1, m_h2, m_h3, m_pe, m_en;
  logic        m_mode, m_valid, m_gap;
  int          m_id, m_ptr;
  logic [31:0] n_pe, n_en;
  logic        n_mode, n_valid, n_gap;
  int          n_id, n_ptr;

  always_comb begin
    logic [31:0] pend, elig, clr, rise;
    int start, c;
    logic found;
    rise = m_h2 & ~m_h3 & EDGE;
    pend = m_pe | (m_h2 & ~EDGE);
    elig = pend & m_en;
    clr = '0;
    if (cfg_wr && cfg_addr == 2'd1) clr = cfg_wdata & EDGE;
    if (m_valid && irq_ack && ((EDGE >> m_id) & 32'd1) != 0) clr = clr | (32'd1 << m_id);
    n_pe = (m_pe & ~clr) | rise;
    n_en = (cfg_wr && cfg_addr == 2'd0) ? cfg_wdata : m_en;
    n_mode = (cfg_wr && cfg_addr == 2'd2) ? cfg_wdata[0] : m_mode;
    n_valid = m_valid;
    n_gap = 1'b0;
    n_id = m_id;
    n_ptr = m_ptr;
    start = m_mode ? m_ptr : 0;
    found = 1'b0;
    c = 0;
    if (m_gap) begin
      n_gap = 1'b0;
    end else if (m_valid) begin
      if (irq_ack) begin
        n_valid = 1'b0;
        n_gap = 1'b1;
      end
    end else if (elig != 0) begin
      for (int k = 0; k < 32; k++) begin
        c = (start + k) % 32;
        if (!found && elig[c]) begin
          found = 1'b1;
          n_id = c;
        end
      end
      n_valid = 1'b1;
      n_ptr = (n_id + 1) % 32;
    end
  end

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_h1 <= '0; m_h2 <= '0; m_h3 <= '0; m_pe <= '0; m_en <= '0;
      m_mode <= 1'b0; m_valid <= 1'b0; m_gap <= 1'b0; m_id <= 0; m_ptr <= 0;
    end else begin
      m_h1 <= int_src; m_h2 <= m_h1; m_h3 <= m_h2;
      m_pe <= n_pe; m_en <= n_en; m_mode <= n_mode;
      m_valid <= n_valid; m_gap <= n_gap; m_id <= n_id; m_ptr <= n_ptr;
    end
  end

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return m_en;
      2'd1:    return m_pe | (m_h2 & ~EDGE);
      2'd2:    return {31'b0, m_mode};
      default: return {26'b0, m_valid, 5'(m_id)};
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge PCLK);
      #2;
      if (!done) begin
        chk("model_valid", 32'(irq_valid), 32'(m_valid));
        if (m_valid) chk("model_id", 32'(irq_id), 32'(m_id));
        chk("model_rdata", cfg_rdata, m_rdata(cfg_addr));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #3;
      if (!cfg_wr) cfg_addr = cfg_addr + 2'd1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    step(1);
    cfg_wr = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    cfg_addr = a;
    #1;
    chk(name, cfg_rdata, exp);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
  endtask

  task automatic wait_valid(input int exp_id, input string name);
    int n = 0;
    while (!irq_valid && n < 20) begin
      step(1);
      n++;
    end
    chk({name, "_valid"}, 32'(irq_valid), 32'd1);
    if (irq_valid) chk({name, "_id"}, 32'(irq_id), 32'(exp_id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_exp[4];
    rr_exp = '{1, 4, 9, 1};

    // Reset and register access
    step(2);
    chk("rst_valid", 32'(irq_valid), 32'd0);
    for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, "rst_rdata");
    PRESETn = 1'b1;
    step(1);
    wr(2'd0, 32'h0000_0707);
    rd(2'd0, 32'h0000_0707, "enable_rb");
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h0000_0001, "mode_rb");
    wr(2'd2, 32'h0);
    wr(2'd0, 32'h0);

    // Level source latency and re-presentation after GAP
    wr(2'd0, 32'h1);
    int_src[0] = 1'b1;
    step(1); chk("lvl_k", 32'(irq_valid), 32'd0);
    step(1); chk("lvl_k1", 32'(irq_valid), 32'd0);
    step(1); chk("lvl_k2_valid", 32'(irq_valid), 32'd1);
    chk("lvl_k2_id", 32'(irq_id), 32'd0);
    rd(2'd3, 32'h20, "lvl_status");
    ack(); chk("lvl_ack", 32'(irq_valid), 32'd0);
    step(1); chk("lvl_gap", 32'(irq_valid), 32'd0);
    step(1); chk("lvl_rep_valid", 32'(irq_valid), 32'd1);
    chk("lvl_rep_id", 32'(irq_id), 32'd0);
    int_src[0] = 1'b0;
    ack();
    step(4); chk("lvl_done", 32'(irq_valid), 32'd0);
    wr(2'd0, 32'h0);

    // Edge latch of a one-cycle pulse
    wr(2'd0, 32'h100);
    int_src[8] = 1'b1;
    step(1);
    int_src[8] = 1'b0;
    step(2);
    rd(2'd1, 32'h100, "edge_pend");
    chk("edge_pre_grant", 32'(irq_valid), 32'd0);
    step(1); chk("edge_valid", 32'(irq_valid), 32'd1);
    chk("edge_id", 32'(irq_id), 32'd8);
    rd(2'd3, 32'h28, "edge_status");
    ack();
    rd(2'd1, 32'h0, "edge_clr");
    step(4); chk("edge_no_rep", 32'(irq_valid), 32'd0);
    wr(2'd0, 32'h0);

    // Fixed priority, then round-robin from a fresh reset
    wr(2'd0, 32'h212);
    int_src = 32'h212;
    for (int i = 0; i < 3; i++) begin
      wait_valid(1, "fixed");
      ack();
    end
    PRESETn = 1'b0;
    step(1);
    chk("fixed_rst", 32'(irq_valid), 32'd0);
    PRESETn = 1'b1;
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h212);
    for (int i = 0; i < 4; i++) begin
      wait_valid(rr_exp[i], "rr");
      ack();
    end
    int_src = '0;
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h0);
    step(4);

    // Masked pending, then enable, then W1C while presented
    int_src[12] = 1'b1;
    step(1);
    int_src[12] = 1'b0;
    step(3);
    rd(2'd1, 32'h1000, "mask_pend");
    chk("mask_valid", 32'(irq_valid), 32'd0);
    wr(2'd0, 32'h1000);
    chk("mask_en_edge", 32'(irq_valid), 32'd0);
    step(1); chk("mask_valid_on", 32'(irq_valid), 32'd1);
    chk("mask_id", 32'(irq_id), 32'd12);
    wr(2'd1, 32'h1000);
    rd(2'd1, 32'h0, "w1c_pend");
    chk("w1c_hold", 32'(irq_valid), 32'd1);
    chk("w1c_id", 32'(irq_id), 32'd12);
    step(2); chk("w1c_hold2", 32'(irq_valid), 32'd1);
    ack(); chk("w1c_ack", 32'(irq_valid), 32'd0);
    step(4); chk("w1c_done", 32'(irq_valid), 32'd0);
    wr(2'd0, 32'h0);

    // New edge coinciding with ack of the same edge source
    wr(2'd0, 32'h400);
    int_src[10] = 1'b1;
    step(1);
    int_src[10] = 1'b0;
    wait_valid(10, "coll_first");
    int_src[10] = 1'b1;
    step(1);
    int_src[10] = 1'b0;
    step(1);
    ack();
    rd(2'd1, 32'h400, "coll_pend");
    chk("coll_ack", 32'(irq_valid), 32'd0);
    step(1); chk("coll_gap", 32'(irq_valid), 32'd0);
    step(1); chk("coll_rep_valid", 32'(irq_valid), 32'd1);
    chk("coll_rep_id", 32'(irq_id), 32'd10);
    ack();
    rd(2'd1, 32'h0, "coll_clr");
    step(4); chk("coll_done", 32'(irq_valid), 32'd0);
    wr(2'd0, 32'h0);

    // Asynchronous reset while presenting
    wr(2'd0, 32'h1);
    int_src[0] = 1'b1;
    wait_valid(0, "rst_mid_pre");
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(irq_valid), 32'd0);
    rd(2'd0, 32'h0, "rst_mid_en");
    int_src = '0;
    step(1);
    PRESETn = 1'b1;
    step(2);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
